// File: rtl/if_queue_if.sv
// Handshake bundle for the instruction fetch queue.
// The fetch side carries words into the queue and the decode side takes them out.
// The master modport is the environment (fetch unit plus decoder); the slave is the queue.
interface if_queue_if #(
    parameter int WIDTH = 32
);
    logic             fetch_valid;
    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] fetch_instr;
    logic             fetch_ready;
    logic             dec_valid;
    logic [WIDTH-1:0] dec_pc;
    logic [WIDTH-1:0] dec_instr;
    logic             dec_ready;
    logic             flush;

    modport master (
        output fetch_valid, fetch_pc, fetch_instr, dec_ready, flush,
        input  fetch_ready, dec_valid, dec_pc, dec_instr
    );

    modport slave (
        input  fetch_valid, fetch_pc, fetch_instr, dec_ready, flush,
        output fetch_ready, dec_valid, dec_pc, dec_instr
    );
endinterface

// File: rtl/if_queue.sv
// Instruction fetch queue: a circular FIFO of {pc, instr} pairs between fetch and decode.
// Optional feature macro IF_QUEUE_BYPASS_EN: when the queue is empty, a valid fetch word
// is forwarded combinationally to decode. If decode takes it, the word is never stored.
// Without the macro, fetch_* reach dec_* only through storage, one cycle after the push.
module if_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    if_queue_if.slave              q,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic [WIDTH-1:0] instr_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic empty;
    logic push;
    logic wr_en;
    logic rd_en;

    assign empty         = (count_q == '0);
    assign q.fetch_ready = (count_q != CNT_W'(DEPTH));
    assign count         = count_q;
    assign push          = q.fetch_valid && q.fetch_ready && !q.flush;
    assign rd_en         = q.dec_ready && !empty && !q.flush;

`ifdef IF_QUEUE_BYPASS_EN
    logic byp;
    assign byp   = empty && q.fetch_valid && !q.flush;
    // A bypassed word that decode accepts is consumed and never written
    assign wr_en = push && !(byp && q.dec_ready);

    // Head entry when occupied, otherwise the live fetch word, otherwise zero
    always_comb begin
        q.dec_valid = 1'b0;
        q.dec_pc    = '0;
        q.dec_instr = '0;
        if (!empty) begin
            q.dec_valid = 1'b1;
            q.dec_pc    = pc_mem[rd_ptr_q];
            q.dec_instr = instr_mem[rd_ptr_q];
        end else if (byp) begin
            q.dec_valid = 1'b1;
            q.dec_pc    = q.fetch_pc;
            q.dec_instr = q.fetch_instr;
        end
    end
`else
    assign wr_en = push;

    // Head entry from storage only; zero while empty so stale words never show
    always_comb begin
        q.dec_valid = 1'b0;
        q.dec_pc    = '0;
        q.dec_instr = '0;
        if (!empty) begin
            q.dec_valid = 1'b1;
            q.dec_pc    = pc_mem[rd_ptr_q];
            q.dec_instr = instr_mem[rd_ptr_q];
        end
    end
`endif

    // Next pointers and occupancy; flush wins over any push or pop this cycle
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (q.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state, cleared asynchronously by the active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is written only on a push; its contents are hidden while empty
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wr_ptr_q]    <= q.fetch_pc;
            instr_mem[wr_ptr_q] <= q.fetch_instr;
        end
    end
endmodule
